// File: rtl/alu_shared_multiplier_pkg.sv
// ============================================================================
// Module : alu_shared_multiplier_pkg
// Brief  : Shared constants and state encoding for the shared-ALU multiplier.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package alu_shared_multiplier_pkg;

  localparam logic [2:0] ALU_FN_ADD = 3'b010;
  localparam int         MULT_ITERS = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_SIGN = 2'd2
  } mult_state_t;

endpackage

`default_nettype wire

// File: rtl/mult_sign_fix.sv
// ============================================================================
// Module : mult_sign_fix
// Brief  : Combinational conditional two's-complement negate.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mult_sign_fix #(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);

  assign y = neg ? ((~x) + {{(W-1){1'b0}}, 1'b1}) : x;

endmodule

`default_nettype wire

// File: rtl/alu_shared_multiplier.sv
// ============================================================================
// Module : alu_shared_multiplier
// Brief  : Iterative shift-add 32x32->64 multiplier borrowing the execute ALU.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module alu_shared_multiplier
  import alu_shared_multiplier_pkg::*;
#(
  parameter int         WIDTH   = MULT_ITERS,
  parameter logic [2:0] ALU_ADD = ALU_FN_ADD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             alu_req,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_f,
  input  logic [WIDTH-1:0] alu_out,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  mult_state_t        state, next_state;
  logic [WIDTH-1:0]   mcand, acc_hi, acc_lo;
  logic [CW-1:0]      count;
  logic               neg;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [2*WIDTH-1:0] prod;
  logic               carry;

  mult_sign_fix #(.W(WIDTH)) u_abs_a (
    .neg (sgn & src_a[WIDTH-1]),
    .x   (src_a),
    .y   (abs_a)
  );

  mult_sign_fix #(.W(WIDTH)) u_abs_b (
    .neg (sgn & src_b[WIDTH-1]),
    .x   (src_b),
    .y   (abs_b)
  );

  mult_sign_fix #(.W(2*WIDTH)) u_fix (
    .neg (neg),
    .x   ({acc_hi, acc_lo}),
    .y   (prod)
  );

  // Carry-out of the 32-bit ALU add, rebuilt from operand and result sign bits.
  assign carry = (alu_a[WIDTH-1] & alu_b[WIDTH-1]) |
                 ((alu_a[WIDTH-1] | alu_b[WIDTH-1]) & ~alu_out[WIDTH-1]);

  assign alu_f = ALU_ADD;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    alu_req    = 1'b0;
    alu_a      = '0;
    alu_b      = '0;
    busy       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) next_state = ST_RUN;
      end
      ST_RUN: begin
        busy    = 1'b1;
        alu_req = 1'b1;
        alu_a   = acc_hi;
        alu_b   = acc_lo[0] ? mcand : '0;
        if (count == CW'(WIDTH-1)) next_state = ST_SIGN;
      end
      ST_SIGN: begin
        busy       = 1'b1;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      neg    <= 1'b0;
      count  <= '0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            mcand  <= abs_a;
            acc_hi <= '0;
            acc_lo <= abs_b;
            neg    <= sgn & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
            count  <= '0;
          end
        end
        ST_RUN: begin
          acc_hi <= {carry, alu_out[WIDTH-1:1]};
          acc_lo <= {alu_out[0], acc_lo[WIDTH-1:1]};
          count  <= count + 1'b1;
        end
        ST_SIGN: begin
          hi   <= prod[2*WIDTH-1:WIDTH];
          lo   <= prod[WIDTH-1:0];
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_shared_multiplier.sv
// ============================================================================
// Module : tb_alu_shared_multiplier
// Brief  : Scoreboard bench for the shared-ALU multiplier.
// Rev    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_alu_shared_multiplier;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        sgn = 1'b0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        alu_req;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [2:0]  alu_f;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [63:0] prod;
    int          done_cyc;
  } exp_t;
  exp_t exp_q[$];

  alu_shared_multiplier dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .sgn     (sgn),
    .src_a   (src_a),
    .src_b   (src_b),
    .alu_req (alu_req),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_f   (alu_f),
    .alu_out (alu_out),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  // Execute ALU model: only ADD is meaningful here.
  assign alu_out = (alu_f == 3'b010) ? (alu_a + alu_b) : 32'hDEAD_BEEF;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endfunction

  // Monitor: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (rst && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("product", {hi, lo}, e.prod);
        check("latency", 64'(cyc), 64'(e.done_cyc));
      end
    end
  end

  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] p, input bit expect_it);
    exp_t e;
    @(negedge clk);
    sgn = s; src_a = a; src_b = b; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (expect_it) begin
      e.prod = p;
      e.done_cyc = cyc + 33;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_done(output int nbusy);
    bit seen = 0;
    nbusy = 0;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
      else if (busy) nbusy++;
    end
    if (!seen) check("done_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int nb;
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_hi_lo", {hi, lo}, 64'd0);
    check("rst_ctrl", {61'd0, done, busy, alu_req}, 64'd0);
    check("rst_alu_ab", {alu_a, alu_b}, 64'd0);
    check("rst_alu_f", 64'(alu_f), 64'd2);
    rst = 1'b1;

    // 1: basic unsigned, latency and busy length
    issue(1'b0, 32'd3, 32'd5, 64'h0000_0000_0000_000F, 1'b1);
    wait_done(nb);
    check("busy_cycles", 64'(nb), 64'd33);
    check("busy_in_done", 64'(busy), 64'd0);

    // 2: unsigned carry path
    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1);
    wait_done(nb);

    // 3: signed
    issue(1'b1, 32'hFFFF_FFF9, 32'd3, 64'hFFFF_FFFF_FFFF_FFEB, 1'b1);
    wait_done(nb);
    issue(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 1'b1);
    wait_done(nb);

    // 4: most-negative operands
    issue(1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b1);
    wait_done(nb);
    issue(1'b1, 32'h8000_0000, 32'd1, 64'hFFFF_FFFF_8000_0000, 1'b1);
    wait_done(nb);

    // 5: start while busy is ignored; start held into done cycle is accepted
    issue(1'b0, 32'd2, 32'd3, 64'd6, 1'b1);
    repeat (8) @(posedge clk);
    @(negedge clk);
    src_a = 32'd9; src_b = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    start = 1'b1;
    wait_done(nb);
    begin
      exp_t e;
      e.prod = 64'h51;
      e.done_cyc = cyc + 1 + 33;
      exp_q.push_back(e);
    end
    @(negedge clk);
    check("busy_after_b2b", 64'(busy), 64'd1);
    start = 1'b0;
    wait_done(nb);

    // 6: reset mid-operation aborts with no done
    issue(1'b0, 32'd5, 32'd5, 64'd25, 1'b0);
    repeat (14) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("abort_hi_lo", {hi, lo}, 64'd0);
    check("abort_ctrl", {61'd0, done, busy, alu_req}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    check("post_abort_hi_lo", {hi, lo}, 64'd0);
    check("post_abort_busy", 64'(busy), 64'd0);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
